// File: rtl/serial_parity_checker_if.sv
// Bundles the serial input side and the parallel output side of the parity checker.
// master = line driver / consumer view, slave = checker view.
interface serial_parity_checker_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             in_sof;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_parity_err;
    logic [7:0]       err_count;

    modport master (
        output in_valid,
        output in_bit,
        output in_sof,
        input  out_valid,
        input  out_data,
        input  out_parity_err,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  in_sof,
        output out_valid,
        output out_data,
        output out_parity_err,
        output err_count
    );
endinterface

// File: rtl/serial_parity_checker.sv
// Receive side of the XOR-parity serial link: collects WIDTH LSB-first data bits plus a
// parity bit, flags parity mismatches and keeps a saturating count of bad frames.
module serial_parity_checker #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    serial_parity_checker_if.slave bus
);
    localparam int              IDXW     = $clog2(WIDTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [7:0]      CNT_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_DATA   = 2'b01,
        ST_PARITY = 2'b10
    } state_e;

    // acc holds the XOR of all data bits so far; the parity bit closes the check.
    function automatic logic frame_parity_err(input logic acc, input logic par_bit);
        return acc ^ par_bit ^ PARITY_ODD;
    endfunction

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] shift_q,     shift_d;
    logic             acc_q,       acc_d;
    logic [IDXW-1:0]  idx_q,       idx_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_err_q,   out_err_d;
    logic [7:0]       err_cnt_q,   err_cnt_d;
    logic             frame_err_s;

    // Next-state and output decode; only valid cycles move anything.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;
        frame_err_s = 1'b0;

        if (bus.in_valid) begin
            if (bus.in_sof) begin
                // SOF always starts a fresh frame; any partial frame is dropped silently.
                shift_d = {{(WIDTH-1){1'b0}}, bus.in_bit};
                acc_d   = bus.in_bit;
                idx_d   = IDX_ONE;
                state_d = ST_DATA;
            end else begin
                case (state_q)
                    ST_HUNT: begin
                        state_d = ST_HUNT;
                    end
                    ST_DATA: begin
                        shift_d[idx_q] = bus.in_bit;
                        acc_d          = acc_q ^ bus.in_bit;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = {IDXW{1'b0}};
                            state_d = ST_PARITY;
                        end else begin
                            idx_d   = idx_q + IDX_ONE;
                            state_d = ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        frame_err_s = frame_parity_err(acc_q, bus.in_bit);
                        out_valid_d = 1'b1;
                        out_data_d  = shift_q;
                        out_err_d   = frame_err_s;
                        if (frame_err_s && (err_cnt_q != CNT_MAX)) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                        acc_d   = 1'b0;
                        idx_d   = {IDXW{1'b0}};
                        state_d = ST_HUNT;
                    end
                    default: begin
                        acc_d   = 1'b0;
                        idx_d   = {IDXW{1'b0}};
                        state_d = ST_HUNT;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            shift_q     <= {WIDTH{1'b0}};
            acc_q       <= 1'b0;
            idx_q       <= {IDXW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_parity_err = out_err_q;
    assign bus.err_count      = err_cnt_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// Drives an even- and an odd-parity checker with the same serial stream and compares both
// against a bit-queue reference model every cycle.
module tb_serial_parity_checker;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_parity_checker_if #(.WIDTH(WIDTH)) ev_if ();
    serial_parity_checker_if #(.WIDTH(WIDTH)) od_if ();

    assign od_if.in_valid = ev_if.in_valid;
    assign od_if.in_bit   = ev_if.in_bit;
    assign od_if.in_sof   = ev_if.in_sof;

    serial_parity_checker #(.WIDTH(WIDTH), .PARITY_ODD(1'b0)) dut_even (
        .clk (clk),
        .rst (rst),
        .bus (ev_if.slave)
    );

    serial_parity_checker #(.WIDTH(WIDTH), .PARITY_ODD(1'b1)) dut_odd (
        .clk (clk),
        .rst (rst),
        .bus (od_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    // Reference model state: the bits of the frame in progress and the expected outputs.
    logic       bits_q[$];
    bit         in_frame = 1'b0;
    logic       m_valid  = 1'b0;
    logic [7:0] m_data   = 8'd0;
    logic       m_err_e  = 1'b0;
    logic       m_err_o  = 1'b0;
    int         m_cnt_e  = 0;
    int         m_cnt_o  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0] word;
        int         ones;
        m_valid = 1'b0;
        if (rst) begin
            bits_q.delete();
            in_frame = 1'b0;
            m_data   = 8'd0;
            m_err_e  = 1'b0;
            m_err_o  = 1'b0;
            m_cnt_e  = 0;
            m_cnt_o  = 0;
        end else if (ev_if.in_valid === 1'b1) begin
            if (ev_if.in_sof === 1'b1) begin
                bits_q.delete();
                bits_q.push_back(ev_if.in_bit);
                in_frame = 1'b1;
            end else if (in_frame) begin
                bits_q.push_back(ev_if.in_bit);
                if (bits_q.size() == WIDTH + 1) begin
                    word = 8'd0;
                    for (int i = 0; i < WIDTH; i++) word[i] = bits_q[i];
                    ones    = $countones(word) + int'(bits_q[WIDTH]);
                    m_data  = word;
                    m_err_e = (ones % 2) != 0;
                    m_err_o = (ones % 2) == 0;
                    m_valid = 1'b1;
                    if (m_err_e && m_cnt_e < 255) m_cnt_e++;
                    if (m_err_o && m_cnt_o < 255) m_cnt_o++;
                    bits_q.delete();
                    in_frame = 1'b0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_eq("valid_ev", 32'(ev_if.out_valid), 32'(m_valid));
                check_eq("valid_od", 32'(od_if.out_valid), 32'(m_valid));
                check_eq("data_ev", 32'(ev_if.out_data), 32'(m_data));
                check_eq("data_od", 32'(od_if.out_data), 32'(m_data));
                check_eq("err_ev", 32'(ev_if.out_parity_err), 32'(m_err_e));
                check_eq("err_od", 32'(od_if.out_parity_err), 32'(m_err_o));
                check_eq("cnt_ev", 32'(ev_if.err_count), 32'(m_cnt_e));
                check_eq("cnt_od", 32'(od_if.err_count), 32'(m_cnt_o));
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic s);
        @(posedge clk);
        #1;
        ev_if.in_valid = v;
        ev_if.in_bit   = b;
        ev_if.in_sof   = s;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic send_frame(input logic [7:0] word, input logic par, input int maxgap);
        drive(1'b1, word[0], 1'b1);
        for (int i = 1; i < WIDTH; i++) begin
            if (maxgap > 0) gap($urandom_range(maxgap, 1));
            drive(1'b1, word[i], 1'b0);
        end
        if (maxgap > 0) gap($urandom_range(maxgap, 1));
        drive(1'b1, par, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst            = 1'b1;
        ev_if.in_valid = 1'b1;
        ev_if.in_sof   = 1'b1;
        ev_if.in_bit   = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst            = 1'b0;
        ev_if.in_valid = 1'b0;
        ev_if.in_sof   = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        ev_if.in_valid = 1'b0;
        ev_if.in_bit   = 1'b0;
        ev_if.in_sof   = 1'b0;
        do_reset(2);
        mon_en = 1'b1;
        gap(2);

        // good even frame, then bad-even/good-odd frame
        send_frame(8'hA5, 1'b0, 0);
        gap(2);
        send_frame(8'hA5, 1'b1, 0);
        gap(2);
        @(negedge clk);
        check_eq("cnt_after_bad", 32'(ev_if.err_count), 32'd1);

        // gapped frame then back-to-back frame
        send_frame(8'hA5, 1'b0, 5);
        send_frame(8'h3C, 1'b0, 0);
        gap(3);

        // aborted frame after 4 data bits, then resync frame
        drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'($urandom), 1'b0);
        send_frame(8'h81, 1'b0, 0);
        gap(3);

        // valid bits in HUNT without SOF, then reset mid-frame, then a clean frame
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'($urandom), 1'b0);
        do_reset(1);
        @(negedge clk);
        check_eq("rst_data", 32'(ev_if.out_data), 32'd0);
        check_eq("rst_cnt", 32'(ev_if.err_count), 32'd0);
        send_frame(8'h5A, 1'b0, 0);
        gap(2);

        // saturation of the even checker's error counter
        for (int f = 0; f < 260; f++) begin
            w = 8'($urandom);
            send_frame(w, ~(^w), 0);
        end
        gap(2);
        @(negedge clk);
        check_eq("cnt_sat", 32'(ev_if.err_count), 32'd255);

        // random stream with random gaps, SOFs and an occasional reset
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset(1);
            drive(1'($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom_range(7, 0) == 0));
        end
        for (int f = 0; f < 20; f++) send_frame(8'($urandom), 1'($urandom), $urandom_range(2, 0));
        gap(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
